cache_flush_ctrl: RTL and testbench
===================================

Name: cache_flush_ctrl

Overview:
- Cache maintenance sequencer that acts as the master of a cache status array's read/write port (valid/dirty bits per set).
- On a flush request it walks every set in index order.
- For each valid-and-dirty set it requests a memory write-back and waits for acknowledgement; every set is then cleared.
- Sits beside the cache control FSM; while `busy` is high, the cache datapath muxes the status array's port to this block.

Parameters:
- s_index, 3, log2 of number of sets (num_sets = 2**s_index)
- width, 2, status word width; bit [1] = valid, bit [0] = dirty, bits above [1] unused and cleared

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- flush_req  input  1  start flush; sampled only in IDLE
- busy  output  1  controller owns the status array port
- flush_done  output  1  one-cycle pulse when flush completes
- wb_count  output  s_index+1  write-backs issued in the most recent flush
- arr_rindex  output  s_index  status array read index
- arr_dataout  input  width  status array read data, combinational from arr_rindex
- arr_load  output  1  status array write enable
- arr_windex  output  s_index  status array write index
- arr_datain  output  width  status array write data
- wb_req  output  1  write-back request to memory interface
- wb_index  output  s_index  set index of the write-back
- wb_ack  input  1  memory interface has accepted/completed the write-back

Behaviour:
- Single clock domain. `rst` is synchronous and active-high. Reset forces IDLE, idx=0, wb_count=0 and all outputs 0. It does not touch array contents; reset in mid-flush abandons the flush with no `flush_done`.
- Internal counter `idx` is s_index bits wide.
- `arr_rindex = arr_windex = wb_index = idx` at all times.
- `arr_datain` is always '0 (clear valid and dirty).
- IDLE:
  - busy=0.
  - flush_req=1 → idx<=0, wb_count<=0, next SCAN.
  - Otherwise stay in IDLE.
- SCAN (busy=1): examine arr_dataout for set idx in the same cycle.
  - valid&dirty=1 → arr_load=0, next WB.
  - Otherwise → arr_load=1 (clear set idx).
    - If idx==num_sets-1 → DONE.
    - Else idx<=idx+1, stay in SCAN.
  - Result: one cycle per clean or invalid set.
- WB (busy=1): wb_req=1, held until wb_ack.
  - wb_ack=1 → arr_load=1 (clear set idx) in the same cycle, wb_req drops next cycle, wb_count<=wb_count+1.
    - If idx==num_sets-1 → DONE.
    - Else idx<=idx+1, next SCAN.
  - wb_ack=0 → stay in WB, no array write.
- DONE: busy=1, flush_done=1 for exactly one cycle, next IDLE. wb_count holds its value until the next flush starts.
- Dirty-but-invalid sets (valid=0, dirty=1) are not written back; they are cleared like clean sets.
- flush_req in SCAN/WB/DONE is ignored, not queued.
- wb_ack outside WB is ignored.
- wb_req only rises in WB; wb_index is stable while wb_req=1.
- arr_load is asserted exactly once per set per flush.
- idx does not wrap during a flush; the last set routes to DONE.
- Latency: an all-clean flush with flush_req at edge 0 gives SCAN on cycles 1..num_sets, flush_done on cycle num_sets+1, and busy=0 from cycle num_sets+2.
- Each write-back adds (cycles until wb_ack)+1 cycles.

Test Plan:
- Reset, then hold flush_req=0 for 5 cycles → busy=0, wb_req=0, arr_load=0, flush_done never asserts.
- All 8 sets status=2'b00, pulse flush_req → arr_load high 8 consecutive cycles with windex 0..7, datain=0, flush_done on cycle 9, wb_count=0.
- Sets 2 and 7 = 2'b11, others 2'b10; wb_ack returned 3 cycles after each wb_req:
  - wb_req rises with wb_index=2, then again with wb_index=7.
  - Each set is cleared only in its ack cycle.
  - wb_count=2, array all zero afterwards.
- Set 5 = 2'b01 (dirty, invalid) → no wb_req; set 5 cleared in SCAN.
- flush_req held high through an entire flush → exactly one flush_done per flush; a new flush starts only from IDLE, with 1 idle cycle between flushes.
- rst asserted while in WB at idx=3 → next cycle: busy=0, wb_req=0, wb_count=0, no flush_done; sets 3..7 keep their prior contents.

Source files
------------

// File: rtl/cache_flush_ctrl.sv
// Cache maintenance sequencer: on a flush request, walks every status-array set in
// index order, writes back valid+dirty sets through the memory interface, and clears every set.
module cache_flush_ctrl #(
  parameter int s_index = 3,
  parameter int width   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_req,
  output logic               busy,
  output logic               flush_done,
  output logic [s_index:0]   wb_count,
  output logic [s_index-1:0] arr_rindex,
  input  logic [width-1:0]   arr_dataout,
  output logic               arr_load,
  output logic [s_index-1:0] arr_windex,
  output logic [width-1:0]   arr_datain,
  output logic               wb_req,
  output logic [s_index-1:0] wb_index,
  input  logic               wb_ack
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WB,
    DONE
  } state_e;

  localparam logic [s_index-1:0] LastIdx = {s_index{1'b1}};

  state_e             state_q, state_d;
  logic [s_index-1:0] idx_q, idx_d;
  logic [s_index:0]   wb_count_q, wb_count_d;

  logic needWb;
  logic lastSet;

  // Only sets that are both valid and dirty hold data memory does not have.
  assign needWb  = arr_dataout[1] & arr_dataout[0];
  assign lastSet = (idx_q == LastIdx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      wb_count_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wb_count_q <= wb_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wb_count_d = wb_count_q;
    unique case (state_q)
      IDLE: begin
        if (flush_req) begin
          idx_d      = '0;
          wb_count_d = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (needWb) begin
          state_d = WB;
        end else if (lastSet) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      WB: begin
        if (wb_ack) begin
          wb_count_d = wb_count_q + 1'b1;
          if (lastSet) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A set is cleared in the cycle it is resolved: immediately if clean, on the ack if written back.
  always_comb begin
    busy       = 1'b0;
    flush_done = 1'b0;
    wb_req     = 1'b0;
    arr_load   = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
      end
      SCAN: begin
        busy     = 1'b1;
        arr_load = ~needWb;
      end
      WB: begin
        busy     = 1'b1;
        wb_req   = 1'b1;
        arr_load = wb_ack;
      end
      DONE: begin
        busy       = 1'b1;
        flush_done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign arr_rindex = idx_q;
  assign arr_windex = idx_q;
  assign wb_index   = idx_q;
  assign arr_datain = '0;
  assign wb_count   = wb_count_q;

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Self-checking bench for cache_flush_ctrl: a behavioural status array plus a flush-level
// reference model (expected write-back list, clear order and completion cycle).
module tb_cache_flush_ctrl;

  localparam int SI = 3;
  localparam int W  = 2;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_req;
  logic          busy;
  logic          flush_done;
  logic [SI:0]   wb_count;
  logic [SI-1:0] arr_rindex;
  logic [W-1:0]  arr_dataout;
  logic          arr_load;
  logic [SI-1:0] arr_windex;
  logic [W-1:0]  arr_datain;
  logic          wb_req;
  logic [SI-1:0] wb_index;
  logic          wb_ack;

  logic [W-1:0]  mem [N];
  logic [W-1:0]  saved [N];

  bit            pendW;
  logic [SI-1:0] pendIdx;
  logic [W-1:0]  pendData;

  int tests = 0;
  int fails = 0;
  int ackDelays[$];

  cache_flush_ctrl #(.s_index(SI), .width(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_req  (flush_req),
    .busy       (busy),
    .flush_done (flush_done),
    .wb_count   (wb_count),
    .arr_rindex (arr_rindex),
    .arr_dataout(arr_dataout),
    .arr_load   (arr_load),
    .arr_windex (arr_windex),
    .arr_datain (arr_datain),
    .wb_req     (wb_req),
    .wb_index   (wb_index),
    .wb_ack     (wb_ack)
  );

  always #5 clk = ~clk;

  assign arr_dataout = mem[arr_rindex];

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Finish the current cycle; array writes land just after the edge so the DUT never sees them early.
  task automatic advance();
    @(posedge clk);
    #1;
    if (pendW) mem[pendIdx] = pendData;
    pendW = 1'b0;
    @(negedge clk);
  endtask

  task automatic applyReset();
    pendW     = 1'b0;
    rst       = 1'b1;
    flush_req = 1'b0;
    wb_ack    = 1'b0;
    advance();
    advance();
    rst = 1'b0;
  endtask

  task automatic runFlush(input bit holdReq, input string name);
    int expWb[$];
    int wbSeen[$];
    int loadSeen[$];
    int expDone;
    int doneCycle = -1;
    int doneCount = 0;
    int waitCnt = 0;
    int dq = 0;
    int curDelay;
    bit prevReq = 1'b0;
    bit sawDone = 1'b0;
    logic [SI-1:0] reqIdx = '0;

    for (int i = 0; i < N; i++) begin
      if (mem[i][1] && mem[i][0]) expWb.push_back(i);
    end
    expDone = N + 1;
    for (int k = 0; k < expWb.size(); k++) begin
      expDone += ((k < ackDelays.size()) ? ackDelays[k] : 0) + 1;
    end

    flush_req = 1'b1;
    wb_ack    = 1'b0;
    advance();
    for (int cyc = 1; cyc <= 300; cyc++) begin
      flush_req = holdReq ? 1'b1 : 1'($urandom_range(0, 1));
      curDelay  = (dq < ackDelays.size()) ? ackDelays[dq] : 0;
      if (wb_req) wb_ack = (waitCnt == curDelay);
      else        wb_ack = 1'($urandom_range(0, 1));
      #1;
      checkOutput({name, " busy"}, 32'(busy), 1);
      checkOutput({name, " index_alias"}, 32'(arr_windex), 32'(arr_rindex));
      if (wb_req && !prevReq) begin
        wbSeen.push_back(int'(wb_index));
        reqIdx = wb_index;
      end
      if (wb_req && prevReq) checkOutput({name, " wb_index_stable"}, 32'(wb_index), 32'(reqIdx));
      if (arr_load) begin
        loadSeen.push_back(int'(arr_windex));
        checkOutput({name, " datain_zero"}, 32'(arr_datain), 0);
        if (wb_req) checkOutput({name, " clear_on_ack"}, 32'(wb_ack), 1);
        pendW    = 1'b1;
        pendIdx  = arr_windex;
        pendData = arr_datain;
      end
      if (flush_done) begin
        doneCount++;
        doneCycle = cyc;
      end
      if (wb_req) begin
        if (wb_ack) begin
          waitCnt = 0;
          dq++;
        end else begin
          waitCnt++;
        end
      end
      prevReq = wb_req;
      sawDone = flush_done;
      advance();
      if (sawDone) break;
    end
    if (!sawDone) checkOutput({name, " flush_timeout"}, 0, 1);

    flush_req = holdReq;
    wb_ack    = 1'b0;
    #1;
    checkOutput({name, " idle_busy"}, 32'(busy), 0);
    checkOutput({name, " idle_done"}, 32'(flush_done), 0);
    checkOutput({name, " idle_wb_req"}, 32'(wb_req), 0);
    checkOutput({name, " wb_count"}, 32'(wb_count), 32'(expWb.size()));
    checkOutput({name, " done_cycle"}, 32'(doneCycle), 32'(expDone));
    checkOutput({name, " done_count"}, 32'(doneCount), 1);
    checkOutput({name, " wb_num"}, 32'(wbSeen.size()), 32'(expWb.size()));
    for (int i = 0; i < expWb.size() && i < wbSeen.size(); i++) begin
      checkOutput({name, " wb_order"}, 32'(wbSeen[i]), 32'(expWb[i]));
    end
    checkOutput({name, " load_num"}, 32'(loadSeen.size()), N);
    for (int i = 0; i < N && i < loadSeen.size(); i++) begin
      checkOutput({name, " load_order"}, 32'(loadSeen[i]), 32'(i));
    end
    for (int i = 0; i < N; i++) begin
      checkOutput({name, " array_clear"}, 32'(mem[i]), 0);
    end
    if (holdReq) begin
      advance();
      #1;
      checkOutput({name, " restart_busy"}, 32'(busy), 1);
      checkOutput({name, " restart_done"}, 32'(flush_done), 0);
    end
  endtask

  initial begin
    bit found;
    for (int i = 0; i < N; i++) mem[i] = '0;
    applyReset();

    // Idle with no request.
    for (int c = 0; c < 5; c++) begin
      flush_req = 1'b0;
      wb_ack    = 1'($urandom_range(0, 1));
      #1;
      checkOutput("reset_busy", 32'(busy), 0);
      checkOutput("reset_wb_req", 32'(wb_req), 0);
      checkOutput("reset_arr_load", 32'(arr_load), 0);
      checkOutput("reset_flush_done", 32'(flush_done), 0);
      checkOutput("reset_wb_count", 32'(wb_count), 0);
      advance();
    end

    // All sets clean and invalid.
    for (int i = 0; i < N; i++) mem[i] = 2'b00;
    ackDelays.delete();
    runFlush(1'b0, "all_clean");

    // Sets 2 and 7 need write-back, acked 3 cycles after request.
    for (int i = 0; i < N; i++) mem[i] = 2'b10;
    mem[2] = 2'b11;
    mem[7] = 2'b11;
    ackDelays = '{3, 3};
    runFlush(1'b0, "two_dirty");

    // Dirty-but-invalid set is only cleared.
    for (int i = 0; i < N; i++) mem[i] = 2'b00;
    mem[5] = 2'b01;
    ackDelays.delete();
    runFlush(1'b0, "dirty_invalid");

    // Request held high across the whole flush.
    for (int i = 0; i < N; i++) mem[i] = 2'(i % 4);
    ackDelays = '{1, 0};
    runFlush(1'b1, "held_req");
    applyReset();

    // Randomised contents and ack latencies.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) mem[i] = 2'($urandom_range(0, 3));
      ackDelays.delete();
      for (int k = 0; k < N; k++) ackDelays.push_back(int'($urandom_range(0, 4)));
      runFlush(1'b0, "random");
    end

    // Reset while waiting for a write-back ack at set 3.
    mem[0] = 2'b10;
    mem[1] = 2'b11;
    mem[2] = 2'b00;
    mem[3] = 2'b11;
    for (int i = 4; i < N; i++) mem[i] = 2'($urandom_range(0, 3));
    for (int i = 3; i < N; i++) saved[i] = mem[i];
    flush_req = 1'b1;
    wb_ack    = 1'b0;
    advance();
    flush_req = 1'b0;
    found     = 1'b0;
    for (int c = 0; c < 50; c++) begin
      wb_ack = wb_req && (wb_index == 3'd1);
      #1;
      if (arr_load) begin
        pendW    = 1'b1;
        pendIdx  = arr_windex;
        pendData = arr_datain;
      end
      if (wb_req && wb_index == 3'd3) begin
        found = 1'b1;
        break;
      end
      advance();
    end
    checkOutput("midwb_reached", 32'(found), 1);
    checkOutput("midwb_count_before", 32'(wb_count), 1);
    checkOutput("midwb_no_load", 32'(arr_load), 0);
    rst = 1'b1;
    advance();
    #1;
    checkOutput("midwb_busy", 32'(busy), 0);
    checkOutput("midwb_wb_req", 32'(wb_req), 0);
    checkOutput("midwb_wb_count", 32'(wb_count), 0);
    checkOutput("midwb_done", 32'(flush_done), 0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      wb_ack = 1'($urandom_range(0, 1));
      #1;
      checkOutput("post_reset_busy", 32'(busy), 0);
      checkOutput("post_reset_done", 32'(flush_done), 0);
      checkOutput("post_reset_load", 32'(arr_load), 0);
      advance();
    end
    for (int i = 3; i < N; i++) begin
      checkOutput("midwb_sets_kept", 32'(mem[i]), 32'(saved[i]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
